// File: rtl/branch_pc_unit.sv
// Fetch-PC sequencer behind the branch comparator: resolves branch/jal/jalr
// targets, redirects fetch, drives a timed flush, produces link values and traps misaligned targets.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  localparam int         REG_LEN      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_valid,
  input  logic [1:0]         br_type,
  input  logic               b,
  input  logic [REG_LEN-1:0] br_pc,
  input  logic [REG_LEN-1:0] br_imm,
  input  logic [REG_LEN-1:0] rs1_d,
  input  logic               restart,
  output logic [REG_LEN-1:0] pc,
  output logic               pc_valid,
  output logic               flush,
  output logic [REG_LEN-1:0] link_d,
  output logic               link_valid,
  output logic               misalign
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [REG_LEN-1:0] pc_q, pc_d;
  logic               pc_valid_q, pc_valid_d;
  logic               flush_q, flush_d;
  logic [REG_LEN-1:0] link_d_q, link_d_d;
  logic               link_valid_q, link_valid_d;
  logic               misalign_q, misalign_d;

  logic [REG_LEN-1:0] target_br, target_jalr, target, pc_inc;
  logic               is_jump, taken, misaligned;

  always_comb begin
    target_br   = br_pc + br_imm;
    target_jalr = (rs1_d + br_imm) & ~32'h0000_0001;
    target      = (br_type == 2'b10) ? target_jalr : target_br;
    is_jump     = (br_type == 2'b01) || (br_type == 2'b10);
    taken       = br_valid && (((br_type == 2'b00) && b) || is_jump);
    misaligned  = taken && target[1];
    pc_inc      = pc_q + 32'd4;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    flush_d      = flush_q;
    link_d_d     = link_d_q;
    link_valid_d = 1'b0;
    misalign_d   = misalign_q;

    case (state_q)
      ST_RUN: begin
        pc_valid_d = 1'b1;
        flush_d    = 1'b0;
        // A redirect wins over stall; stall only gates the +4 step.
        if (taken && !misaligned) begin
          pc_d    = target;
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
          flush_d = 1'b1;
        end else if (taken) begin
          state_d    = ST_TRAP;
          misalign_d = 1'b1;
          flush_d    = 1'b1;
          pc_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
        // Link is produced even when the jump target turns out misaligned.
        if (br_valid && is_jump) begin
          link_d_d     = br_pc + 32'd4;
          link_valid_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        pc_valid_d = 1'b1;
        if (!stall) pc_d = pc_inc;
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      ST_TRAP: begin
        if (restart) begin
          pc_d       = RESET_PC;
          state_d    = ST_RUN;
          misalign_d = 1'b0;
          flush_d    = 1'b0;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= 4'd0;
      pc_q         <= RESET_PC;
      pc_valid_q   <= 1'b0;
      flush_q      <= 1'b0;
      link_d_q     <= '0;
      link_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      flush_q      <= flush_d;
      link_d_q     <= link_d_d;
      link_valid_q <= link_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign flush      = flush_q;
  assign link_d     = link_d_q;
  assign link_valid = link_valid_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: linear steps with hand-computed expected values.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_valid, b, restart;
  logic [1:0]  br_type;
  logic [31:0] br_pc, br_imm, rs1_d;
  logic [31:0] pc, link_d;
  logic        pc_valid, flush, link_valid, misalign;

  int n_cmp = 0;
  int n_err = 0;

  branch_pc_unit #(.RESET_PC(32'h0), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid),
    .br_type(br_type), .b(b), .br_pc(br_pc), .br_imm(br_imm),
    .rs1_d(rs1_d), .restart(restart), .pc(pc), .pc_valid(pc_valid),
    .flush(flush), .link_d(link_d), .link_valid(link_valid),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc,
                           input logic e_vld, input logic e_fl, input logic e_mis);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, e_vld});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_valid = 1'b0; b = 1'b0; restart = 1'b0;
    br_type = 2'b00; br_pc = '0; br_imm = '0; rs1_d = '0;

    #2;
    chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("reset.link_d", link_d, 32'h0);
    chk("reset.link_valid", {31'd0, link_valid}, 32'h0);

    #10 rst_n = 1'b1;
    chk("rel.pc", pc, 32'h0);
    step(); chk_state("free1", 32'h4, 1'b1, 1'b0, 1'b0);
    step(); chk_state("free2", 32'h8, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    step(); chk_state("stall", 32'h8, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    step(); chk_state("free3", 32'hC, 1'b1, 1'b0, 1'b0);

    // Conditional taken branch, then a jal presented during FLUSH.
    br_valid = 1'b1; br_type = 2'b00; b = 1'b1; br_pc = 32'h10; br_imm = 32'h20;
    step(); chk_state("br_taken", 32'h30, 1'b1, 1'b1, 1'b0);
    chk("br_taken.link_valid", {31'd0, link_valid}, 32'h0);
    br_type = 2'b01;
    step(); chk_state("flush_ign", 32'h34, 1'b1, 1'b1, 1'b0);
    chk("flush_ign.link_valid", {31'd0, link_valid}, 32'h0);
    br_valid = 1'b0; br_type = 2'b00;
    step(); chk_state("flush_end", 32'h38, 1'b1, 1'b0, 1'b0);

    br_valid = 1'b1; b = 1'b0;
    step(); chk_state("br_not", 32'h3C, 1'b1, 1'b0, 1'b0);
    br_type = 2'b11; b = 1'b1;
    step(); chk_state("type11", 32'h40, 1'b1, 1'b0, 1'b0);
    chk("type11.link_valid", {31'd0, link_valid}, 32'h0);

    // jalr: (0x101+3)&~1 = 0x104
    br_type = 2'b10; rs1_d = 32'h101; br_imm = 32'h3; br_pc = 32'h10;
    step(); chk_state("jalr", 32'h104, 1'b1, 1'b1, 1'b0);
    chk("jalr.link_d", link_d, 32'h14);
    chk("jalr.link_valid", {31'd0, link_valid}, 32'h1);
    br_valid = 1'b0;
    step(); chk_state("jalr2", 32'h108, 1'b1, 1'b1, 1'b0);
    chk("jalr2.link_valid", {31'd0, link_valid}, 32'h0);
    chk("jalr2.link_d", link_d, 32'h14);
    step(); chk_state("jalr3", 32'h10C, 1'b1, 1'b0, 1'b0);

    restart = 1'b1;
    step(); chk_state("restart_run", 32'h110, 1'b1, 1'b0, 1'b0);
    restart = 1'b0;

    // Misaligned jal: 0x8+0x6 = 0xE
    br_valid = 1'b1; br_type = 2'b01; br_pc = 32'h8; br_imm = 32'h6;
    step(); chk_state("trap", 32'h110, 1'b0, 1'b1, 1'b1);
    chk("trap.link_d", link_d, 32'hC);
    chk("trap.link_valid", {31'd0, link_valid}, 32'h1);
    br_imm = 32'h8;
    step(); chk_state("trap_h1", 32'h110, 1'b0, 1'b1, 1'b1);
    chk("trap_h1.link_valid", {31'd0, link_valid}, 32'h0);
    br_valid = 1'b0;
    step(); chk_state("trap_h2", 32'h110, 1'b0, 1'b1, 1'b1);
    step(); chk_state("trap_h3", 32'h110, 1'b0, 1'b1, 1'b1);
    restart = 1'b1;
    step(); chk_state("trap_exit", 32'h0, 1'b1, 1'b0, 1'b0);
    restart = 1'b0;

    // jal from br_pc=0xFFFFFFFC: link wraps to 0, target 0x10.
    br_valid = 1'b1; br_type = 2'b01; br_pc = 32'hFFFF_FFFC; br_imm = 32'h14;
    step(); chk_state("jal_wrap", 32'h10, 1'b1, 1'b1, 1'b0);
    chk("jal_wrap.link_d", link_d, 32'h0);
    chk("jal_wrap.link_valid", {31'd0, link_valid}, 32'h1);
    br_valid = 1'b0;
    step(); step(); chk_state("jal_wrap_end", 32'h18, 1'b1, 1'b0, 1'b0);

    // Redirect to 0xFFFFFFF4 then free-run across the wrap.
    br_valid = 1'b1; br_type = 2'b00; b = 1'b1; br_pc = 32'hFFFF_FFF0; br_imm = 32'h4;
    step(); chk("wrap.pc0", pc, 32'hFFFF_FFF4);
    br_valid = 1'b0;
    step(); step(); chk_state("wrap.fc", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    step(); chk_state("wrap.zero", 32'h0, 1'b1, 1'b0, 1'b0);

    // Branch target wraps: 0xFFFFFFF0+0x20 = 0x10.
    br_valid = 1'b1; br_imm = 32'h20;
    step(); chk_state("br_wrap", 32'h10, 1'b1, 1'b1, 1'b0);
    br_valid = 1'b0;
    step(); chk_state("mid_flush", 32'h14, 1'b1, 1'b1, 1'b0);

    // Async reset between edges, mid-FLUSH.
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    chk("async_rst.link_d", link_d, 32'h0);
    #1 rst_n = 1'b1;
    step(); chk_state("post_rst", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter sequencer directly downstream of the branch comparator. It consumes the one-bit compare result `b` together with the resolving instruction's type, PC and immediate.
- Computes the branch/jump target, redirects the fetch PC and asserts a multi-cycle pipeline flush. It also produces the jal/jalr link value.
- Misaligned taken targets are trapped in a halt state until an explicit restart.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset and on restart.
- FLUSH_CYCLES, 2: cycles `flush` stays high after a redirect; legal range 1..15.
- Data width is `REG_LEN` from rysy_pkg.vh (32). It is not a parameter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold sequential PC increment
- br_valid  in  1  execute-stage instruction is a branch/jump this cycle
- br_type  in  2  00 conditional branch, 01 jal, 10 jalr, 11 reserved (treated as not taken)
- b  in  1  compare result from branch comparator
- br_pc  in  REG_LEN  PC of resolving instruction
- br_imm  in  REG_LEN  sign-extended offset
- rs1_d  in  REG_LEN  jalr base register value
- restart  in  1  leave TRAP state
- pc  out  REG_LEN  current fetch PC (registered)
- pc_valid  out  1  fetch request valid
- flush  out  1  kill younger in-flight instructions
- link_d  out  REG_LEN  registered br_pc+4 for jal/jalr
- link_valid  out  1  one-cycle pulse, link_d valid
- misalign  out  1  sticky misaligned-target flag

Behaviour:
- Reset (rst_n low, asynchronous) forces the following, regardless of clk:
  - pc=RESET_PC, state=RUN, flush counter=0
  - pc_valid=0 while rst_n is low; pc_valid=1 from the first rising edge after release
  - flush=0, link_d=0, link_valid=0, misalign=0
- Target computation; all arithmetic is modulo 2^REG_LEN, and overflow/wrap is silent:
  - branch and jal: br_pc+br_imm
  - jalr: (rs1_d+br_imm) & ~1
- taken = br_valid & ((br_type==00 & b) | br_type==01 | br_type==10). Not evaluated in FLUSH or TRAP, because those instructions are being killed.
- misaligned = taken & target[1].
- States:
  - RUN:
    - taken & !misaligned at edge N: pc<=target; state<=FLUSH; counter<=FLUSH_CYCLES-1. flush is high from edge N for exactly FLUSH_CYCLES cycles.
    - taken & misaligned: pc held; state<=TRAP; misalign<=1; flush<=1; pc_valid<=0.
    - Otherwise: pc<=pc+4 when !stall, else hold.
  - FLUSH:
    - flush=1; pc<=pc+4 when !stall, else hold.
    - Counter decrements every cycle, including stalled cycles.
    - At counter==0 the next state is RUN and flush drops.
  - TRAP:
    - pc held, pc_valid=0, flush=1, misalign=1.
    - restart=1 at an edge: pc<=RESET_PC, state<=RUN, misalign<=0, flush<=0, pc_valid<=1.
    - restart is ignored outside TRAP.
- Priority: a redirect overrides stall. stall affects only the +4 increment.
- Link: any jal/jalr accepted in RUN, including a misaligned one, gives link_d<=br_pc+4 and link_valid=1 for one cycle. link_d holds its value afterwards. br_pc=0xFFFFFFFC gives link_d=0.
- pc=0xFFFFFFFC with no redirect: next pc=0x00000000, with no flag.
- br_type 11 behaves as not taken and produces no link.
- Asserting reset mid-FLUSH or in TRAP aborts immediately to the reset values.

Test Plan:
- Free run, RESET_PC=0, FLUSH_CYCLES=2: release reset, stall high only in cycle 3 -> pc sequence 0,4,8,8,C; flush=0 throughout.
- Conditional taken: RUN, br_valid=1, br_type=00, b=1, br_pc=0x10, br_imm=0x20 -> next pc=0x30; flush high exactly 2 cycles; pc then 0x34, 0x38. Same stimulus with b=0 -> no redirect, flush=0.
- jalr: br_type=10, rs1_d=0x101, br_imm=0x3, br_pc=0x10 -> pc=0x104, link_d=0x14, link_valid pulses one cycle.
- Misaligned jal: br_type=01, br_pc=0x8, br_imm=0x6 (target 0xE) -> pc held, misalign=1, pc_valid=0, flush=1, link_d=0xC. Hold 3 cycles, then restart=1 -> pc=0, misalign=0, pc_valid=1.
- Ignore rules: second taken branch presented during FLUSH -> ignored, pc keeps +4. restart pulsed in RUN -> no effect.
- Boundaries:
  - pc=0xFFFFFFFC free-running -> pc=0.
  - Branch br_pc=0xFFFFFFF0, br_imm=0x20 -> pc=0x10.
  - rst_n dropped between edges mid-FLUSH -> pc=RESET_PC and flush=0 immediately, without waiting for a clock edge.
